// File: rtl/soc_pkg.sv
// ---------------------------------------------------------------------------
// soc_pkg
// Shared SoC-level types and defaults.
//   boot_state_t    : boot sequencer state encoding
//   DEF_ADDR_SIZE   : default ROM/RAM address width
//   DEF_WORD_SIZE   : default data word width
// ---------------------------------------------------------------------------
package soc_pkg;

    localparam int DEF_ADDR_SIZE = 8;
    localparam int DEF_WORD_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE,
        COPY,
        VERIFY,
        DONE,
        FAIL
    } boot_state_t;

endpackage

// File: rtl/boot_cksum.sv
// ---------------------------------------------------------------------------
// boot_cksum
// Modulo-2^WORD_SIZE additive checksum accumulator. Clear has priority over
// enable; the sum is registered.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset (sum -> 0)
//   clear    in   zero the sum on the next edge
//   en       in   add data_in into the sum on the next edge
//   data_in  in   WORD_SIZE word to accumulate
//   sum      out  current accumulated value
// ---------------------------------------------------------------------------
module boot_cksum
    import soc_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 en,
    input  logic [WORD_SIZE-1:0] data_in,
    output logic [WORD_SIZE-1:0] sum
);

    logic [WORD_SIZE-1:0] sum_d;
    logic [WORD_SIZE-1:0] sum_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        sum_d = sum_q;
        if (clear) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = sum_q + data_in;
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/boot_loader.sv
// ---------------------------------------------------------------------------
// boot_loader
// Boot sequencer: holds the CPU in boot mode, copies IMG_LEN words from ROM
// (starting at SRC_BASE) into RAM (starting at DST_BASE) one word per cycle,
// then compares the running sum with the checksum word at SRC_BASE+IMG_LEN.
// The CPU is released (boot=0) only after a verified image.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin / re-run a load; honoured in IDLE, DONE and FAIL
//   rom_addr   out  ROM read address
//   rom_data   in   ROM read data, combinational on rom_addr
//   ram_addr   out  RAM write address
//   ram_wdata  out  RAM write data (rom_data while copying, else 0)
//   ram_wr_en  out  RAM write strobe
//   boot       out  CPU held in boot mode
//   busy       out  copying or verifying
//   done       out  image loaded and verified (sticky)
//   error      out  checksum mismatch (sticky)
//   checksum   out  running / final checksum
// ---------------------------------------------------------------------------
module boot_loader
    import soc_pkg::*;
#(
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int WORD_SIZE  = DEF_WORD_SIZE,
    parameter int IMG_LEN    = 16,
    parameter int SRC_BASE   = 0,
    parameter int DST_BASE   = 0,
    parameter int AUTO_START = 1,
    parameter int CHECK_EN   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [ADDR_SIZE-1:0] rom_addr,
    input  logic [WORD_SIZE-1:0] rom_data,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [WORD_SIZE-1:0] ram_wdata,
    output logic                 ram_wr_en,
    output logic                 boot,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [WORD_SIZE-1:0] checksum
);

    localparam logic [ADDR_SIZE-1:0] SRC_W  = ADDR_SIZE'(SRC_BASE);
    localparam logic [ADDR_SIZE-1:0] DST_W  = ADDR_SIZE'(DST_BASE);
    localparam logic [ADDR_SIZE-1:0] LAST_W = ADDR_SIZE'(IMG_LEN - 1);

    // State entered once the last word is copied, and the state a start
    // leads to (an empty image skips COPY entirely).
    localparam boot_state_t END_STATE   = (CHECK_EN != 0) ? VERIFY : DONE;
    localparam boot_state_t START_STATE = (IMG_LEN == 0) ? END_STATE : COPY;

    boot_state_t          state_d, state_q;
    logic [ADDR_SIZE-1:0] cnt_d, cnt_q;
    logic                 boot_d, boot_q;
    logic                 busy_d, busy_q;
    logic                 done_d, done_q;
    logic                 error_d, error_q;
    logic                 ck_clear;
    logic                 ck_en;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ck_clear = 1'b0;
        ck_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((AUTO_START != 0) || start) begin
                    state_d = START_STATE;
                end
            end
            COPY: begin
                ck_en = 1'b1;
                cnt_d = cnt_q + ADDR_SIZE'(1);
                if (cnt_q == LAST_W) begin
                    state_d = END_STATE;
                end
            end
            VERIFY: begin
                // cnt_q == IMG_LEN here, so rom_addr points at the checksum.
                state_d = (rom_data == checksum) ? DONE : FAIL;
            end
            DONE, FAIL: begin
                if (start) begin
                    ck_clear = 1'b1;
                    cnt_d    = '0;
                    state_d  = START_STATE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with state_q and never depend combinationally on start.
        boot_d  = (state_d != DONE);
        busy_d  = (state_d == COPY) || (state_d == VERIFY);
        done_d  = (state_d == DONE);
        error_d = (state_d == FAIL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            boot_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            boot_q  <= boot_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    boot_cksum #(
        .WORD_SIZE (WORD_SIZE)
    ) u_cksum (
        .clk     (clk),
        .rst     (rst),
        .clear   (ck_clear),
        .en      (ck_en),
        .data_in (rom_data),
        .sum     (checksum)
    );

    // Address arithmetic wraps silently at ADDR_SIZE bits.
    assign rom_addr  = SRC_W + cnt_q;
    assign ram_addr  = DST_W + cnt_q;
    assign ram_wr_en = (state_q == COPY);
    assign ram_wdata = (state_q == COPY) ? rom_data : '0;
    assign boot      = boot_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Parametrised boot sequencer for the single-CPU SoC.
- Holds the CPU in boot mode, copies a program image from ROM into RAM one word per cycle, and verifies it against a checksum stored in ROM.
- Releases the CPU only on a verified image.
- Replaces the ad-hoc ROM-drives-bus boot path with a self-contained, restartable, error-reporting copier.

Parameters:
- ADDR_SIZE, 8: address width of the ROM and RAM ports.
- WORD_SIZE, 8: data word width.
- IMG_LEN, 16: image length in words; legal range 0 to 2^ADDR_SIZE-1.
- SRC_BASE, 0: ROM address of image word 0. The checksum word sits at SRC_BASE+IMG_LEN.
- DST_BASE, 0: RAM address receiving image word 0.
- AUTO_START, 1: 1 = start copying on the first cycle after reset; 0 = wait for a start pulse.
- CHECK_EN, 1: 1 = verify the checksum; 0 = skip the VERIFY state.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: single-cycle request to begin or re-run a load. Only sampled in IDLE, DONE or FAIL.
- rom_addr, output, ADDR_SIZE: ROM read address.
- rom_data, input, WORD_SIZE: ROM read data, combinational on rom_addr.
- ram_addr, output, ADDR_SIZE: RAM write address.
- ram_wdata, output, WORD_SIZE: RAM write data.
- ram_wr_en, output, 1: RAM write strobe; RAM captures on the clk edge while high.
- boot, output, 1: high = CPU held in boot mode and off the bus.
- busy, output, 1: high during COPY and VERIFY.
- done, output, 1: image loaded and verified. Sticky until the next start or rst.
- error, output, 1: checksum mismatch. Sticky until the next start or rst.
- checksum, output, WORD_SIZE: running or final checksum value.

Behaviour:
- Reset values while rst is high, and on the cycle after it falls:
  - state=IDLE, boot=1, busy=0, done=0, error=0, ram_wr_en=0
  - checksum=0, word counter=0, rom_addr=SRC_BASE, ram_addr=DST_BASE, ram_wdata=0
- States: IDLE, COPY, VERIFY, DONE, FAIL.
- IDLE:
  - Moves to COPY on the next edge if AUTO_START=1 or start=1.
  - If IMG_LEN=0, moves directly to VERIFY (or to DONE when CHECK_EN=0).
- COPY, cycle k (k = 0..IMG_LEN-1):
  - Drive rom_addr=SRC_BASE+k, ram_addr=DST_BASE+k, ram_wdata=rom_data, ram_wr_en=1.
  - Register checksum <= checksum + rom_data, modulo 2^WORD_SIZE.
  - On k=IMG_LEN-1, go to VERIFY (or to DONE when CHECK_EN=0).
  - Takes exactly IMG_LEN cycles with one write per cycle; no gaps.
- Addresses are computed modulo 2^ADDR_SIZE; wrap past all-ones to 0 is legal and silent.
- VERIFY (one cycle):
  - rom_addr=SRC_BASE+IMG_LEN, ram_wr_en=0.
  - If rom_data == checksum, go to DONE; otherwise go to FAIL.
- DONE: boot=0, done=1, busy=0. The CPU owns the bus from the first DONE cycle.
- FAIL: boot=1, error=1, busy=0. The CPU stays held.
- DONE or FAIL with start=1: clear done, error, checksum and counter; set boot=1; enter COPY on the next edge.
- start during COPY or VERIFY is ignored.
- rst at any cycle, including mid-COPY, returns to the reset state. No further ram_wr_en is issued in the cycle following rst high. The load restarts from word 0 after reset if AUTO_START=1.
- Latency from rst falling to boot falling: 1 + IMG_LEN + CHECK_EN cycles.
- Outputs are registered or decoded from registered state only; there is no combinational path from start to ram_wr_en.
- ram_wdata follows rom_data combinationally in COPY and is 0 in every other state.

Decomposition:
- Shared package soc_pkg holds:
  - the boot_state_t enum {IDLE, COPY, VERIFY, DONE, FAIL}
  - ADDR_SIZE and WORD_SIZE defaults, matching the top macro values
- One sub-module, boot_cksum: WORD_SIZE accumulator with clear, enable and data_in inputs and a sum output. It is reused later for RAM scrub checks.

Test Plan:
- Default params; ROM[0..15]=1..16, ROM[16]=136. Release rst → 16 consecutive writes RAM[k]=k+1, then boot falls 18 cycles after rst falls, done=1, error=0, checksum=136.
- Same image with ROM[16]=0 → error=1 at cycle 18, boot stays 1, done=0, no RAM writes after cycle 16.
- Assert rst for one cycle at copy word 5 → ram_wr_en=0 the next cycle, then a fresh copy from word 0. Final RAM contents correct, done=1.
- SRC_BASE=250, DST_BASE=252, IMG_LEN=8, ADDR_SIZE=8 → ram_addr sequence 252..255,0..3 and rom_addr wraps likewise. Checksum read from ROM[2] matches, done=1.
- AUTO_START=0, IMG_LEN=0, CHECK_EN=1, ROM[SRC_BASE]=0 → stays in IDLE with boot=1 until a start pulse. Then one VERIFY cycle, done=1, and zero writes.
- After DONE, pulse start with the ROM image modified → boot rises the next cycle, the new image is copied, and done reasserts. A start pulsed mid-COPY has no effect.
